mtm_alu_serializer: RTL and testbench



---
 rtl/mtm_alu_serializer.sv | 144 ++++++++++++++
 tb/tb_mtm_alu_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer: transmit-side framer for the ALU serial port.
// Sends a 5-packet data frame (4 data bytes + CTL byte) or a 1-packet
// error frame; each packet is start(0), type, 8 payload bits MSB first, stop(1).
// Optional feature macro: MTM_ALU_SER_CRC_EN (CRC-3 in the CTL byte).
// Without it the CRC field is sent as 3'b000.
module mtm_alu_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] C,
    input  logic [3:0]  flags,
    input  logic        err,
    input  logic [5:0]  err_flags,
    output logic        sout,
    output logic        busy
);

    localparam int unsigned HOLD_W   = 40;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned CRC_W    = 3;
    localparam int unsigned CRC_IN_W = 37;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TYPE,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold;
    logic                err_q;
    logic [CNT_W-1:0]    pkt_cnt;
    logic [CNT_W-1:0]    bit_cnt;

    logic [7:0]          cur_byte_c;
    logic                last_pkt_c;
    logic [CRC_W-1:0]    crc_c;
    logic [7:0]          ctl_data_c;
    logic [7:0]          ctl_err_c;

`ifdef MTM_ALU_SER_CRC_EN
    // CRC-3 (x^3+x+1, init 0) over the word, MSB first
    function automatic logic [CRC_W-1:0] crc3(input logic [CRC_IN_W-1:0] w);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = '0;
        for (int i = CRC_IN_W - 1; i >= 0; i--) begin
            fb  = w[i] ^ crc[2];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

    assign crc_c = crc3({C, 1'b0, flags});
`else
    assign crc_c = 3'b000;
`endif

    // CTL payloads for the two frame kinds
    assign ctl_data_c = {1'b0, flags, crc_c};
    assign ctl_err_c  = {1'b1, err_flags, ^{1'b1, err_flags}};

    // The error frame carries its CTL byte in packet slot 0 and ends there
    assign last_pkt_c = err_q | (pkt_cnt == CNT_W'(4));

    // Payload byte selected by the packet counter
    always_comb begin
        cur_byte_c = hold[7:0];
        case (pkt_cnt)
            3'd0:    cur_byte_c = hold[39:32];
            3'd1:    cur_byte_c = hold[31:24];
            3'd2:    cur_byte_c = hold[23:16];
            3'd3:    cur_byte_c = hold[15:8];
            default: cur_byte_c = hold[7:0];
        endcase
    end

    // Framing FSM; state names the bit currently on sout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sout    <= 1'b1;
            busy    <= 1'b0;
            hold    <= '0;
            err_q   <= 1'b0;
            pkt_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    sout <= 1'b1;
                    busy <= 1'b0;
                    if (in_valid) begin
                        hold    <= err ? {ctl_err_c, 32'h0} : {C, ctl_data_c};
                        err_q   <= err;
                        pkt_cnt <= '0;
                        bit_cnt <= '0;
                        sout    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    sout  <= last_pkt_c;
                    state <= S_TYPE;
                end
                S_TYPE: begin
                    sout    <= cur_byte_c[7];
                    bit_cnt <= CNT_W'(7);
                    state   <= S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt == '0) begin
                        sout  <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        sout    <= cur_byte_c[bit_cnt - CNT_W'(1)];
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (last_pkt_c) begin
                        sout    <= 1'b1;
                        busy    <= 1'b0;
                        pkt_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        sout    <= 1'b0;
                        pkt_cnt <= pkt_cnt + CNT_W'(1);
                        state   <= S_START;
                    end
                end
                default: begin
                    sout  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: expected frame bits are
// queued at the accept edge and popped cycle by cycle as sout is sampled.
module tb_mtm_alu_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] C;
    logic [3:0]  flags;
    logic        err;
    logic [5:0]  err_flags;
    logic        sout;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    bit         exp_q[$];
    logic [7:0] obs_pl[5];

    mtm_alu_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .C         (C),
        .flags     (flags),
        .err       (err),
        .err_flags (err_flags),
        .sout      (sout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CRC by polynomial long division of word * x^3 by 1011
    function automatic logic [2:0] ref_crc(input logic [36:0] w);
        logic [39:0] r;
        r = {w, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    task automatic push_pkt(input bit typ, input logic [7:0] pl);
        exp_q.push_back(1'b0);
        exp_q.push_back(typ);
        for (int b = 7; b >= 0; b--) exp_q.push_back(pl[b]);
        exp_q.push_back(1'b1);
    endtask

    // Expected bit stream for one accepted request
    task automatic push_frame(input logic [31:0] c, input logic [3:0] f,
                              input bit e, input logic [5:0] ef);
        logic [2:0] crc;
        if (e) begin
            push_pkt(1'b1, {1'b1, ef, ^{1'b1, ef}});
        end else begin
`ifdef MTM_ALU_SER_CRC_EN
            crc = ref_crc({c, 1'b0, f});
`else
            crc = 3'b000;
`endif
            push_pkt(1'b0, c[31:24]);
            push_pkt(1'b0, c[23:16]);
            push_pkt(1'b0, c[15:8]);
            push_pkt(1'b0, c[7:0]);
            push_pkt(1'b1, {1'b0, f, crc});
        end
    endtask

    // Called at a negedge: present request, let the next edge accept it
    task automatic send(input logic [31:0] c, input logic [3:0] f,
                        input bit e, input logic [5:0] ef);
        in_valid  = 1'b1;
        C         = c;
        flags     = f;
        err       = e;
        err_flags = ef;
        @(posedge clk);
        push_frame(c, f, e, ef);
        #1;
        in_valid  = 1'b0;
        C         = $urandom;
        flags     = 4'($urandom);
        err_flags = 6'($urandom);
        err       = 1'b0;
    endtask

    // Sample nbits frame bits plus the idle cycle after; optional mid-frame
    // spurious strobe (drop_at) or reset pulse (abort_at), -1 disables
    task automatic collect(input string name, input int nbits,
                           input int drop_at, input int abort_at);
        bit exp_b;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            exp_b = exp_q.pop_front();
            compared++;
            if (sout !== exp_b || busy !== 1'b1) begin
                mismatched++;
                $display("FAIL %s bit %0d: sout=%b busy=%b, required sout=%b busy=1",
                         name, i, sout, busy, exp_b);
            end
            if ((i % 11) >= 2 && (i % 11) <= 9)
                obs_pl[i / 11][9 - (i % 11)] = sout;
            if (i == drop_at) begin
                in_valid  = 1'b1;
                C         = 32'h1234_5678;
                flags     = 4'hF;
                err       = 1'b1;
                err_flags = 6'h3F;
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                err       = 1'b0;
            end
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                compared++;
                if (sout !== 1'b1 || busy !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s abort: sout=%b busy=%b, required sout=1 busy=0",
                             name, sout, busy);
                end
                exp_q.delete();
                return;
            end
        end
        @(negedge clk);
        compared++;
        if (sout !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s gap: sout=%b busy=%b, required sout=1 busy=0",
                     name, sout, busy);
        end
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s leftover: %0d bits queued, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            compared++;
            if (sout !== 1'b1 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL %s cycle %0d: sout=%b busy=%b, required sout=1 busy=0",
                         name, i, sout, busy);
            end
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] got,
                              input logic [7:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: payload=%02h, required %02h", name, got, want);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        compared++;
        if (sout !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold: sout=%b busy=%b, required sout=1 busy=0", sout, busy);
        end
        rst_n = 1'b1;
        check_idle("reset_idle", 100);
    endtask

    task automatic test_zero();
        send(32'h0, 4'h0, 1'b0, 6'h0);
        collect("zero", 55, -1, -1);
        for (int k = 0; k < 5; k++) check_byte("zero_payload", obs_pl[k], 8'h00);
    endtask

    task automatic test_crc();
        send(32'h0, 4'b0001, 1'b0, 6'h0);
        collect("crc", 55, -1, -1);
`ifdef MTM_ALU_SER_CRC_EN
        check_byte("crc_ctl", obs_pl[4], 8'h0B);
`else
        check_byte("crc_ctl", obs_pl[4], 8'h08);
`endif
    endtask

    task automatic test_byte_order();
        send(32'hDEAD_BEEF, 4'b1010, 1'b0, 6'h0);
        collect("order", 55, -1, -1);
        check_byte("order_b0", obs_pl[0], 8'hDE);
        check_byte("order_b1", obs_pl[1], 8'hAD);
        check_byte("order_b2", obs_pl[2], 8'hBE);
        check_byte("order_b3", obs_pl[3], 8'hEF);
    endtask

    task automatic test_error();
        send(32'hFFFF_FFFF, 4'hF, 1'b1, 6'b100100);
        collect("err_c9", 11, -1, -1);
        check_byte("err_c9_payload", obs_pl[0], 8'hC9);
        send(32'h0, 4'h0, 1'b1, 6'b010010);
        collect("err_a5", 11, -1, -1);
        check_byte("err_a5_payload", obs_pl[0], 8'hA5);
    endtask

    // Minimum-gap frames alternating kinds with random content
    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            if (n % 3 == 2) begin
                send($urandom, 4'($urandom), 1'b1, 6'($urandom));
                collect("b2b_err", 11, -1, -1);
            end else begin
                send($urandom, 4'($urandom), 1'b0, 6'($urandom));
                collect("b2b_data", 55, -1, -1);
            end
        end
    endtask

    task automatic test_busy_drop();
        send(32'hA5C3_0F96, 4'b0110, 1'b0, 6'h0);
        collect("drop", 55, 20, -1);
        check_idle("drop_after", 5);
    endtask

    task automatic test_abort();
        send(32'h8000_0001, 4'b1001, 1'b0, 6'h0);
        collect("abort", 55, -1, 30);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle("abort_idle", 70);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        C         = '0;
        flags     = '0;
        err       = 1'b0;
        err_flags = '0;
        test_reset();
        test_zero();
        test_crc();
        test_byte_order();
        test_error();
        test_back_to_back();
        test_busy_drop();
        test_abort();
        send(32'h0BAD_F00D, 4'b0011, 1'b0, 6'h0);
        collect("post_abort", 55, -1, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
